// File: rtl/d7s_scan_ctrl.sv
// Scan scheduler for a shared 3-digit 7-segment display.
// Double-buffers BCD loads, swaps them in at frame boundaries, and time-shares
// the segment bus across three digit transistors with a blank gap between slots.
module d7s_scan_ctrl #(
   parameter int unsigned DWELL_CYC     = 50000,
   parameter int unsigned BLANK_CYC     = 500,
   parameter int unsigned TR_ACTIVE_LOW = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_valid,
   output logic        load_ready,
   input  logic [11:0] load_data,
   input  logic        lz_en,
   output logic [2:0]  transistor,
   output logic [6:0]  d7sp,
   output logic        frame_tick
);

   localparam int unsigned CNT_MAX = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
   localparam logic [2:0] TR_IDLE = (TR_ACTIVE_LOW != 0) ? 3'b111 : 3'b000;

   typedef enum logic {ST_BLANK, ST_SHOW} state_t;

   state_t           state_q, state_d;
   logic [1:0]       dig_q, dig_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [11:0]      act_q, act_d;
   logic [11:0]      pend_q, pend_d;
   logic             full_q, full_d;
   logic [2:0]       tr_q, tr_d;
   logic [6:0]       seg_q, seg_d;
   logic             tick_q, tick_d;
   logic [3:0]       nib;
   logic             blank_dig;

   // BCD nibble to segments {g,f,e,d,c,b,a}; non-decimal nibbles show a dash
   function automatic logic [6:0] seg_f(input logic [3:0] b);
      case (b)
         4'd0:    seg_f = 7'h3F;
         4'd1:    seg_f = 7'h06;
         4'd2:    seg_f = 7'h5B;
         4'd3:    seg_f = 7'h4F;
         4'd4:    seg_f = 7'h66;
         4'd5:    seg_f = 7'h6D;
         4'd6:    seg_f = 7'h7D;
         4'd7:    seg_f = 7'h07;
         4'd8:    seg_f = 7'h7F;
         4'd9:    seg_f = 7'h6F;
         default: seg_f = 7'h40;
      endcase
   endfunction

   assign load_ready = ~full_q;
   assign transistor = tr_q;
   assign d7sp       = seg_q;
   assign frame_tick = tick_q;

   // State, buffers and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_BLANK;
         dig_q   <= 2'd0;
         cnt_q   <= '0;
         act_q   <= 12'h000;
         pend_q  <= 12'h000;
         full_q  <= 1'b0;
         tr_q    <= TR_IDLE;
         seg_q   <= 7'h00;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dig_q   <= dig_d;
         cnt_q   <= cnt_d;
         act_q   <= act_d;
         pend_q  <= pend_d;
         full_q  <= full_d;
         tr_q    <= tr_d;
         seg_q   <= seg_d;
         tick_q  <= tick_d;
      end
   end

   // Slot sequencing, handshake, frame swap, and next output values
   always_comb begin
      state_d   = state_q;
      dig_d     = dig_q;
      cnt_d     = cnt_q + CNT_W'(1);
      act_d     = act_q;
      pend_d    = pend_q;
      full_d    = full_q;
      tick_d    = 1'b0;
      tr_d      = TR_IDLE;
      seg_d     = 7'h00;
      nib       = 4'h0;
      blank_dig = 1'b0;

      case (state_q)
         ST_BLANK: begin
            if (cnt_q == BLANK_LAST) begin
               state_d = ST_SHOW;
               cnt_d   = '0;
            end
         end
         ST_SHOW: begin
            if (cnt_q == DWELL_LAST) begin
               state_d = ST_BLANK;
               cnt_d   = '0;
               case (dig_q)
                  2'd0:    dig_d = 2'd1;
                  2'd1:    dig_d = 2'd2;
                  default: dig_d = 2'd0;
               endcase
               // Leaving the last digit closes the frame: tick and swap in new data
               if (dig_q == 2'd2) begin
                  tick_d = 1'b1;
                  if (full_q) begin
                     act_d  = pend_q;
                     full_d = 1'b0;
                  end
               end
            end
         end
         default: begin
            state_d = ST_BLANK;
            dig_d   = 2'd0;
            cnt_d   = '0;
         end
      endcase

      // Accept only when empty, so it can never collide with a swap
      if (load_valid && !full_q) begin
         pend_d = load_data;
         full_d = 1'b1;
      end

      if (state_d == ST_SHOW) begin
         case (dig_d)
            2'd0: nib = act_d[3:0];
            2'd1: begin
               nib       = act_d[7:4];
               blank_dig = lz_en && (act_d[11:8] == 4'h0) && (act_d[7:4] == 4'h0);
            end
            default: begin
               nib       = act_d[11:8];
               blank_dig = lz_en && (act_d[11:8] == 4'h0);
            end
         endcase
         if (!blank_dig) begin
            case (dig_d)
               2'd0:    tr_d = 3'b001 ^ TR_IDLE;
               2'd1:    tr_d = 3'b010 ^ TR_IDLE;
               default: tr_d = 3'b100 ^ TR_IDLE;
            endcase
            seg_d = seg_f(nib);
         end
      end
   end

endmodule
